// File: rtl/axil_if.sv
// AXI-Lite bus bundle with clock and reset, shared by initiators (master modport)
// and targets (slave modport).
interface axil_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clk_i,
   input logic rstn_i
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  clk_i, rstn_i,
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  clk_i, rstn_i,
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AW/W/B or AR/R
// transaction out, one response beat back.
module axil_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   axil_if.master                m_axil,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_we_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]            rsp_resp_o
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WAIT_B,
      RD,
      WAIT_R,
      RSP
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic                  r_rsp_we;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;

   logic w_cmd_fire;
   logic w_aw_fire;
   logic w_w_fire;
   logic w_b_fire;
   logic w_ar_fire;
   logic w_r_fire;
   logic w_aw_complete;
   logic w_w_complete;

   assign cmd_ready_o   = (r_state == IDLE);
   assign w_cmd_fire    = cmd_valid_i & cmd_ready_o;
   assign w_aw_fire     = r_awvalid & m_axil.awready;
   assign w_w_fire      = r_wvalid & m_axil.wready;
   assign w_b_fire      = r_bready & m_axil.bvalid;
   assign w_ar_fire     = r_arvalid & m_axil.arready;
   assign w_r_fire      = r_rready & m_axil.rvalid;
   // A channel counts as complete if it finished earlier or is finishing now.
   assign w_aw_complete = r_aw_done | w_aw_fire;
   assign w_w_complete  = r_w_done | w_w_fire;

   assign m_axil.awaddr  = r_addr;
   assign m_axil.awvalid = r_awvalid;
   assign m_axil.wdata   = r_wdata;
   assign m_axil.wstrb   = r_wstrb;
   assign m_axil.wvalid  = r_wvalid;
   assign m_axil.bready  = r_bready;
   assign m_axil.araddr  = r_addr;
   assign m_axil.arvalid = r_arvalid;
   assign m_axil.rready  = r_rready;

   assign rsp_valid_o = r_rsp_valid;
   assign rsp_we_o    = r_rsp_we;
   assign rsp_rdata_o = r_rsp_rdata;
   assign rsp_resp_o  = r_rsp_resp;

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge m_axil.clk_i) begin
      if (!m_axil.rstn_i) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cmd_fire) begin
                  r_addr  <= cmd_addr_i;
                  r_wdata <= cmd_wdata_i;
                  r_wstrb <= cmd_wstrb_i;
                  if (cmd_we_i) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= RD;
                  end
               end
            end

            WR: begin
               if (w_aw_fire) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_fire) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_complete && w_w_complete) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= WAIT_B;
               end
            end

            WAIT_B: begin
               if (w_b_fire) begin
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_resp  <= m_axil.bresp;
                  r_state     <= RSP;
               end
            end

            RD: begin
               if (w_ar_fire) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= WAIT_R;
               end
            end

            WAIT_R: begin
               if (w_r_fire) begin
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= 1'b0;
                  r_rsp_rdata <= m_axil.rdata;
                  r_rsp_resp  <= m_axil.rresp;
                  r_state     <= RSP;
               end
            end

            RSP: begin
               // Response fields hold their captured values until consumed.
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a configurable AXI-Lite slave model
// with a small word memory, per-channel ready/valid delays and forced responses.
module tb_axil_master;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.clk_i(clk), .rstn_i(rstn));

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we    = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_we;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .m_axil      (bus.master),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .cmd_wstrb_i (cmd_wstrb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_we_o    (rsp_we),
      .rsp_rdata_o (rsp_rdata),
      .rsp_resp_o  (rsp_resp)
   );

   // ---------------- slave model ----------------
   int          cfg_aw_dly = 1, cfg_w_dly = 1, cfg_ar_dly = 1;
   int          cfg_b_extra = 0, cfg_r_extra = 0;
   logic [1:0]  cfg_bresp = 2'd0, cfg_rresp = 2'd0;
   logic        cfg_rd_ovr_en = 1'b0;
   logic [31:0] cfg_rd_ovr = '0;

   logic [31:0] mem [64];
   int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt, s_r_cnt;
   logic        s_aw_got, s_w_got, s_b_pend, s_r_pend;
   logic [31:0] s_awaddr, s_wdata, s_rdata, s_merge;
   logic [3:0]  s_wstrb;
   logic [31:0] s_wr_addr, s_wr_data;
   logic [3:0]  s_wr_strb;
   logic        s_aw_fire, s_w_fire, s_b_fire, s_ar_fire, s_r_fire, s_commit;

   assign bus.awready = bus.awvalid && (s_aw_cnt >= cfg_aw_dly);
   assign bus.wready  = bus.wvalid && (s_w_cnt >= cfg_w_dly);
   assign bus.arready = bus.arvalid && (s_ar_cnt >= cfg_ar_dly);
   assign bus.bvalid  = s_b_pend && (s_b_cnt >= cfg_b_extra);
   assign bus.bresp   = cfg_bresp;
   assign bus.rvalid  = s_r_pend && (s_r_cnt >= cfg_r_extra);
   assign bus.rresp   = cfg_rresp;
   assign bus.rdata   = s_rdata;

   assign s_aw_fire = bus.awvalid & bus.awready;
   assign s_w_fire  = bus.wvalid & bus.wready;
   assign s_b_fire  = bus.bvalid & bus.bready;
   assign s_ar_fire = bus.arvalid & bus.arready;
   assign s_r_fire  = bus.rvalid & bus.rready;
   assign s_commit  = (s_aw_got | s_aw_fire) & (s_w_got | s_w_fire);
   assign s_wr_addr = s_aw_fire ? bus.awaddr : s_awaddr;
   assign s_wr_data = s_w_fire ? bus.wdata : s_wdata;
   assign s_wr_strb = s_w_fire ? bus.wstrb : s_wstrb;

   always_comb begin
      // NOTE: default assignment first so the byte-lane updates never imply a latch.
      s_merge = mem[s_wr_addr[7:2]];
      for (int b = 0; b < 4; b++)
         if (s_wr_strb[b]) s_merge[8*b +: 8] = s_wr_data[8*b +: 8];
   end

   always @(posedge clk) begin
      if (!rstn) begin
         s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_b_cnt <= 0; s_r_cnt <= 0;
         s_aw_got <= 1'b0; s_w_got <= 1'b0; s_b_pend <= 1'b0; s_r_pend <= 1'b0;
         s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
      end else begin
         s_aw_cnt <= (bus.awvalid && !s_aw_fire) ? s_aw_cnt + 1 : 0;
         s_w_cnt  <= (bus.wvalid && !s_w_fire) ? s_w_cnt + 1 : 0;
         s_ar_cnt <= (bus.arvalid && !s_ar_fire) ? s_ar_cnt + 1 : 0;
         if (s_aw_fire) begin s_awaddr <= bus.awaddr; s_aw_got <= 1'b1; end
         if (s_w_fire) begin s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; s_w_got <= 1'b1; end
         if (s_b_pend) begin
            if (s_b_fire) s_b_pend <= 1'b0;
            else s_b_cnt <= s_b_cnt + 1;
         end
         if (s_commit) begin
            mem[s_wr_addr[7:2]] <= s_merge;
            s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_b_pend <= 1'b1; s_b_cnt <= 0;
         end
         if (s_r_pend) begin
            if (s_r_fire) s_r_pend <= 1'b0;
            else s_r_cnt <= s_r_cnt + 1;
         end
         if (s_ar_fire) begin
            s_r_pend <= 1'b1; s_r_cnt <= 0;
            s_rdata  <= cfg_rd_ovr_en ? cfg_rd_ovr : mem[bus.araddr[7:2]];
         end
      end
   end

   // ------------- protocol monitor: valids never drop or change unaccepted -------------
   int          mon_aw_viol = 0, mon_w_viol = 0, mon_ar_viol = 0, mon_rsp_viol = 0;
   int          mon_aw_hs = 0;
   logic        p_rstn = 1'b0, p_awv = 1'b0, p_awf = 1'b0, p_wv = 1'b0, p_wf = 1'b0;
   logic        p_arv = 1'b0, p_arf = 1'b0, p_rv = 1'b0, p_rf = 1'b0;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0, p_rdata = '0;

   always @(posedge clk) begin
      if (p_rstn) begin
         if (p_awv && !p_awf && (!bus.awvalid || bus.awaddr !== p_awaddr)) mon_aw_viol <= mon_aw_viol + 1;
         if (p_wv && !p_wf && (!bus.wvalid || bus.wdata !== p_wdata)) mon_w_viol <= mon_w_viol + 1;
         if (p_arv && !p_arf && (!bus.arvalid || bus.araddr !== p_araddr)) mon_ar_viol <= mon_ar_viol + 1;
         if (p_rv && !p_rf && (!rsp_valid || rsp_rdata !== p_rdata)) mon_rsp_viol <= mon_rsp_viol + 1;
      end
      if (s_aw_fire) mon_aw_hs <= mon_aw_hs + 1;
      p_rstn <= rstn;
      p_awv <= bus.awvalid; p_awf <= s_aw_fire; p_awaddr <= bus.awaddr;
      p_wv  <= bus.wvalid;  p_wf  <= s_w_fire;  p_wdata  <= bus.wdata;
      p_arv <= bus.arvalid; p_arf <= s_ar_fire; p_araddr <= bus.araddr;
      p_rv  <= rsp_valid;   p_rf  <= rsp_valid & rsp_ready; p_rdata <= rsp_rdata;
   end

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge; returns at the negedge after the command handshake.
   task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int acc);
      acc = -1;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      for (int n = 0; n < 60; n++) begin
         if (cmd_ready) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      if (acc < 0) check("cmd_accept_timeout", 1, 0);
   endtask

   // Returns at the first negedge where rsp_valid is high, without consuming it.
   task automatic wait_rsp(output int rc);
      rc = -1;
      for (int n = 0; n < 60; n++) begin
         if (rsp_valid) begin
            rc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (rc < 0) check("rsp_timeout", 1, 0);
   endtask

   task automatic run_cmd(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                          output int acc);
      int rc;
      send_cmd(we, addr, data, strb, acc);
      wait_rsp(rc);
      check({name, "_latency"}, rc - acc, 4);
      check({name, "_we"}, rsp_we, we);
      check({name, "_resp"}, rsp_resp, exp_resp);
      check({name, "_rdata"}, rsp_rdata, exp_rdata);
      @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc, prev_acc, rc, rel;
      logic [6:0]  exp_aw, exp_w, exp_b, exp_rv;
      int          hs_before;

      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, 32'h0};
      vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'd0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h08, 32'h11223344, 4'hF, 2'd0, 32'h0};
      vecs[3] = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h3, 2'd0, 32'h0};
      vecs[4] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'd0, 32'h1122CCDD};
      vecs[5] = '{1'b1, 32'h20, 32'h00000000, 4'hF, 2'd0, 32'h0};
      vecs[6] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'hC, 2'd0, 32'h0};
      vecs[7] = '{1'b0, 32'h20, 32'h0,        4'h0, 2'd0, 32'hCAFE0000};
      vecs[8] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'd0, 32'hDEADBEEF};

      repeat (3) @(negedge clk);
      rstn = 1'b1;
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
      check("reset_readies", {bus.bready, bus.rready}, 0);
      check("reset_rsp_fields", {rsp_we, rsp_resp, rsp_rdata}, 0);
      @(negedge clk);

      // Zero-wait slave, back-to-back commands with rsp_ready held high.
      prev_acc = 0;
      for (int i = 0; i < 9; i++) begin
         run_cmd($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].strb, vecs[i].resp, vecs[i].rdata, acc);
         if (i > 0) check($sformatf("vec%0d_b2b_gap", i), acc - prev_acc, 5);
         prev_acc = acc;
      end

      // Staggered AW/W readiness.
      cfg_w_dly = 4;
      hs_before = mon_aw_hs;
      exp_aw = 7'b0000011; exp_w = 7'b0011111; exp_b = 7'b0100000; exp_rv = 7'b1000000;
      send_cmd(1'b1, 32'h60, 32'h0BADCAFE, 4'hF, acc);
      for (int k = 1; k <= 7; k++) begin
         check($sformatf("stag_awvalid_c%0d", k), bus.awvalid, exp_aw[k-1]);
         check($sformatf("stag_wvalid_c%0d", k), bus.wvalid, exp_w[k-1]);
         check($sformatf("stag_bready_c%0d", k), bus.bready, exp_b[k-1]);
         check($sformatf("stag_rsp_valid_c%0d", k), rsp_valid, exp_rv[k-1]);
         @(negedge clk);
      end
      check("stag_single_aw", mon_aw_hs - hs_before, 1);
      cfg_w_dly = 1;
      run_cmd("stag_readback", 1'b0, 32'h60, 32'h0, 4'h0, 2'd0, 32'h0BADCAFE, acc);

      // Response backpressure: rsp_ready low for 6 cycles.
      rsp_ready = 1'b0;
      send_cmd(1'b0, 32'h10, 32'h0, 4'h0, acc);
      wait_rsp(rc);
      check("bp_latency", rc - acc, 4);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("bp_hold_valid_%0d", k), rsp_valid, 1);
         check($sformatf("bp_hold_rdata_%0d", k), rsp_rdata, 32'hDEADBEEF);
         check($sformatf("bp_hold_cmd_ready_%0d", k), cmd_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_cmd_ready", cmd_ready, 1);
      check("bp_release_rsp_valid", rsp_valid, 0);
      rel = cyc;
      run_cmd("bp_next", 1'b0, 32'h08, 32'h0, 4'h0, 2'd0, 32'h1122CCDD, acc);
      check("bp_next_accept_cycle", acc - rel, 0);

      // Slow B and R: bready/rready held for the whole wait.
      cfg_b_extra = 10; cfg_r_extra = 10;
      for (int t = 0; t < 2; t++) begin
         send_cmd(t == 0, 32'h30, 32'h12345678, 4'hF, acc);
         for (int k = 1; k <= 14; k++) begin
            if (t == 0) check($sformatf("slowb_bready_c%0d", k), bus.bready, (k >= 3 && k <= 13));
            else check($sformatf("slowr_rready_c%0d", k), bus.rready, (k >= 3 && k <= 13));
            check($sformatf("slow%0d_rsp_valid_c%0d", t, k), rsp_valid, (k == 14));
            if (k == 14) check($sformatf("slow%0d_rdata", t), rsp_rdata, (t == 0) ? 32'h0 : 32'h12345678);
            @(negedge clk);
         end
      end
      cfg_b_extra = 0; cfg_r_extra = 0;

      // Error responses pass through untouched.
      cfg_bresp = 2'b10; cfg_rresp = 2'b11; cfg_rd_ovr_en = 1'b1; cfg_rd_ovr = 32'h5A5A5A5A;
      run_cmd("err_write", 1'b1, 32'h40, 32'h01020304, 4'hF, 2'd2, 32'h0, acc);
      run_cmd("err_read", 1'b0, 32'h40, 32'h0, 4'h0, 2'd3, 32'h5A5A5A5A, acc);
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rd_ovr_en = 1'b0;

      // Reset while waiting for B.
      cfg_b_extra = 5;
      send_cmd(1'b1, 32'h50, 32'h77777777, 4'hF, acc);
      repeat (2) @(negedge clk);
      check("rst_in_wait_b", bus.bready, 1);
      rstn = 1'b0;
      @(negedge clk);
      check("rst_valids_low", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
      check("rst_readies_low", {bus.bready, bus.rready}, 0);
      check("rst_no_rsp", rsp_valid, 0);
      rstn = 1'b1;
      cfg_b_extra = 0;
      @(negedge clk);
      check("rst_after_cmd_ready", cmd_ready, 1);
      check("rst_after_no_rsp", rsp_valid, 0);
      run_cmd("rst_after_read", 1'b0, 32'h10, 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, acc);

      check("mon_aw_stable", mon_aw_viol, 0);
      check("mon_w_stable", mon_w_viol, 0);
      check("mon_ar_stable", mon_ar_viol, 0);
      check("mon_rsp_stable", mon_rsp_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
Single-outstanding AXI-Lite initiator. It converts a simple valid/ready command port (read or write, address, data, strobe) into AXI-Lite AW/W/B or AR/R transactions on an axil_if.master port. It returns one response beat per command. It is the initiator-side counterpart to the team's AXI-Lite slaves such as the RAM and register banks, and is used by test harnesses, UART/SPI bridges and control FSMs to reach those slaves.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr_i; must equal the axil_if address width.
DATA_WIDTH, 32, width of data; must equal the axil_if data width (multiple of 8).
STRB_WIDTH, DATA_WIDTH/8, width of cmd_wstrb_i.

Ports:
m_axil.clk_i  input  1  clock, carried in axil_if.
m_axil.rstn_i  input  1  reset, carried in axil_if.
m_axil  axil_if.master  -  AXI-Lite initiator: drives awaddr/awvalid, wdata/wstrb/wvalid, bready, araddr/arvalid, rready; samples the ready/valid/resp/rdata returns.
cmd_valid_i  input  1  command request.
cmd_ready_o  output  1  command accepted this cycle when both are high.
cmd_we_i  input  1  1 = write, 0 = read.
cmd_addr_i  input  ADDR_WIDTH  byte address.
cmd_wdata_i  input  DATA_WIDTH  write data; ignored for reads.
cmd_wstrb_i  input  STRB_WIDTH  byte strobes; ignored for reads.
rsp_valid_o  output  1  response available.
rsp_ready_i  input  1  response consumed.
rsp_we_o  output  1  echo of the command type.
rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes.
rsp_resp_o  output  2  bresp or rresp of the transaction.

Behaviour:
- Single clock, m_axil.clk_i. Reset is synchronous and active-low on m_axil.rstn_i.
- Reset values: all valids 0, bready 0, rready 0, rsp_valid_o 0, rsp_* 0, address/data registers 0, state IDLE. cmd_ready_o is 1 in the first cycle after reset.
- A reset asserted mid-transaction aborts immediately: all valids drop in the next cycle and no response is produced.
- FSM states: IDLE, WR, WAIT_B, RD, WAIT_R, RSP.
- cmd_ready_o = (state == IDLE), combinational from state.
- IDLE:
  - On a command handshake, capture addr, wdata, wstrb and we into registers.
  - we = 1: go to WR; awvalid and wvalid become 1 in the next cycle.
  - we = 0: go to RD; arvalid becomes 1 in the next cycle.
- WR:
  - awvalid and wvalid are tracked independently with aw_done and w_done flags.
  - Each valid deasserts in the cycle after its own handshake; simultaneous and staggered handshakes are both legal.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - When both are done, or both complete in the same cycle, go to WAIT_B.
- WAIT_B:
  - bready = 1 only in this state.
  - On bvalid & bready, capture rsp_resp_o = bresp, set rsp_rdata_o = 0, go to RSP.
- RD:
  - arvalid is held with araddr stable until arready.
  - On handshake, arvalid goes to 0 and the state goes to WAIT_R.
- WAIT_R:
  - rready = 1 only in this state.
  - On rvalid & rready, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid_o = 1, and rsp_* are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE, so cmd_ready_o = 1 in the next cycle.
  - No command/response overlap: at most one command is outstanding.
- No valid is ever dropped without a handshake, except on reset.
- Responses are not interpreted: SLVERR/DECERR pass through unchanged on rsp_resp_o.
- Latency with a zero-wait slave that answers ready the cycle after valid (team axil_ram), command handshake in cycle 0:
  - write: valids in cycle 1, handshake in cycle 2, B handshake in cycle 3, rsp_valid_o in cycle 4.
  - read: same timing, with the R handshake in cycle 3 and rsp_valid_o in cycle 4.
- Back-to-back: with rsp_ready_i held 1, a new command is accepted in cycle 5, giving 5 cycles per transaction.

Test Plan:
- Write then read, against axil_ram: write 0x0000_0010 / 0xDEADBEEF / strb 0xF, then read 0x10 → write rsp_resp_o = 0 and rsp_valid_o in cycle 4; read rsp_rdata_o = 0xDEADBEEF, rsp_resp_o = 0.
- Partial strobe: write 0x11223344 to 0x8, then 0xAABBCCDD to 0x8 with strb 0x3, then read 0x8 → 0x1122CCDD.
- Staggered ready, on a BFM slave: awready 1 cycle after valid, wready 4 cycles after valid → awvalid low from cycle 3, wvalid held through the cycle-5 handshake, bready asserted only after both handshakes; no duplicate AW.
- Backpressure:
  - hold rsp_ready_i = 0 for 6 cycles → rsp_* stable and cmd_ready_o = 0 throughout; the next command is accepted the cycle after rsp_ready_i.
  - BFM delays bvalid/rvalid by 10 cycles → bready/rready held at 1 throughout.
- Error pass-through: BFM returns bresp = 2'b10, then rresp = 2'b11 with rdata 0x5A5A5A5A → rsp_resp_o 2 and 3 respectively, with rsp_rdata_o 0x5A5A5A5A on the read.
- Reset mid-op: assert rstn_i = 0 while in WAIT_B → next cycle all valids, bready and rsp_valid_o are 0; after release, cmd_ready_o = 1 and a new read completes normally.
